player_ctrl: RTL and testbench

Per-player controller that turns button levels into the grid-side request interface: the player coordinate and the one-cycle bomb-set strobe. It drives the `p*_cor` and `p*_set` inputs of the game grid and reads back the grid's wall map, bomb map, bomb capacity and unexploded-bomb count. Two instances are used, one per player, differing only in start coordinate. The block enforces movement legality, move rate, bomb capacity and game-over freeze.

---
 rtl/bomb_pkg.sv | 17 +
 rtl/rise_pulse.sv | 14 +
 rtl/player_ctrl.sv | 75 +++++++
 tb/tb_player_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// bomb_pkg: shared direction, grid geometry and player state types
package bomb_pkg;
  localparam int GRID_W = 16;
  localparam int GRID_CELLS = 256;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
  typedef enum logic [1:0] {ST_IDLE, ST_COOLDOWN, ST_FROZEN} pstate_e;
  function automatic logic [7:0] dir_target(input logic [7:0] c, input dir_e d);
    return d == DIR_UP   ? c - 8'(GRID_W) :
           d == DIR_DOWN ? c + 8'(GRID_W) :
           d == DIR_LEFT ? c - 8'd1 : c + 8'd1;
  endfunction
  function automatic logic at_edge(input logic [7:0] c, input dir_e d);
    return d == DIR_UP   ? c[7:4] == 4'h0 :
           d == DIR_DOWN ? c[7:4] == 4'hf :
           d == DIR_LEFT ? c[3:0] == 4'h0 : c[3:0] == 4'hf;
  endfunction
endpackage

// File: rtl/rise_pulse.sv
// rise_pulse: registered previous level, high in the cycle the input rises
module rise_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic din_q, din_d;
  always_comb din_d = din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) din_q <= 1'b0;
    else din_q <= din_d;
  assign pulse = din & ~din_q;
endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: button levels to grid coordinate and bomb-set strobe, with move cooldown and freeze
module player_ctrl
  import bomb_pkg::*;
#(
  parameter logic [7:0] START_COR = 8'd0,
  parameter int MOVE_GAP = 2_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_bomb,
  input  logic [GRID_CELLS-1:0] wall_grid,
  input  logic [GRID_CELLS-1:0] bomb_grid,
  input  logic [2:0]            bomb_cap,
  input  logic [2:0]            bomb_unexp_num,
  input  logic                  game_over,
  output logic [7:0]            cor,
  output logic                  set,
  output logic [1:0]            facing,
  output logic                  moving
);
  localparam int CW = $clog2(MOVE_GAP + 1);
  pstate_e state_q, state_d;
  dir_e facing_q, facing_d, dir;
  logic [7:0] cor_q, cor_d, tgt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] hist_q, hist_d;
  logic set_q, set_d, moving_q, moving_d;
  logic bomb_rise, any_dir, live, legal, bomb_ok, move_ok;
  rise_pulse u_bomb_rise (.clk(clk), .rst_n(rst_n), .din(btn_bomb), .pulse(bomb_rise));
  always_comb begin
    any_dir  = btn_up | btn_right | btn_down | btn_left;
    dir      = btn_up ? DIR_UP : btn_right ? DIR_RIGHT : btn_down ? DIR_DOWN : DIR_LEFT;
    tgt      = dir_target(cor_q, dir);
    legal    = any_dir & ~at_edge(cor_q, dir) & ~wall_grid[tgt] & ~bomb_grid[tgt];
    live     = state_q != ST_FROZEN;
    bomb_ok  = live & bomb_rise & (bomb_unexp_num < bomb_cap) & ~bomb_grid[cor_q] & ~|hist_q;
    move_ok  = (state_q == ST_IDLE) & legal & ~bomb_ok;
    set_d    = bomb_ok;
    hist_d   = {hist_q[0], set_q};
    cor_d    = move_ok ? tgt : cor_q;
    facing_d = (live & any_dir) ? dir : facing_q;
    cnt_d    = move_ok ? CW'(MOVE_GAP - 1) :
               (state_q == ST_COOLDOWN && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    state_d  = (game_over | ~live) ? ST_FROZEN :
               move_ok ? ST_COOLDOWN :
               (state_q == ST_COOLDOWN && cnt_q == '0) ? ST_IDLE : state_q;
    moving_d = state_d == ST_COOLDOWN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cor_q    <= START_COR;
      set_q    <= 1'b0;
      facing_q <= DIR_DOWN;
      moving_q <= 1'b0;
      cnt_q    <= '0;
      hist_q   <= '0;
    end else begin
      state_q  <= state_d;
      cor_q    <= cor_d;
      set_q    <= set_d;
      facing_q <= facing_d;
      moving_q <= moving_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
    end
  assign cor    = cor_q;
  assign set    = set_q;
  assign facing = facing_q;
  assign moving = moving_q;
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed vectors with hand-computed expectations, MOVE_GAP = 4
module tb_player_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_bomb = 0, game_over = 0;
  logic [255:0] wall_grid = '0, bomb_grid = '0;
  logic [2:0] bomb_cap = 3'd3, bomb_unexp_num = 3'd0;
  logic [7:0] cor, cor2;
  logic set, set2, moving, moving2;
  logic [1:0] facing, facing2;
  int n_chk = 0, n_pass = 0, pulses;
  always #5 clk = ~clk;
  player_ctrl #(.START_COR(8'd0), .MOVE_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_bomb(btn_bomb), .wall_grid(wall_grid), .bomb_grid(bomb_grid),
    .bomb_cap(bomb_cap), .bomb_unexp_num(bomb_unexp_num), .game_over(game_over),
    .cor(cor), .set(set), .facing(facing), .moving(moving));
  player_ctrl #(.START_COR(8'd255), .MOVE_GAP(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_bomb(btn_bomb), .wall_grid(wall_grid), .bomb_grid(bomb_grid),
    .bomb_cap(bomb_cap), .bomb_unexp_num(bomb_unexp_num), .game_over(game_over),
    .cor(cor2), .set(set2), .facing(facing2), .moving(moving2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic move(input int d, input logic [7:0] exp);
    {btn_up, btn_down, btn_left, btn_right} = 4'b1000 >> d;
    tick;
    check("move_cor", cor, exp);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    repeat (5) tick;
  endtask
  initial begin
    repeat (2) tick;
    check("rst_cor", cor, 8'h00);
    check("rst_cor2", cor2, 8'hff);
    check("rst_set", set, 0);
    check("rst_facing", facing, 1);
    check("rst_moving", moving, 0);
    rst_n = 1'b1;
    btn_right = 1'b1;
    tick;
    check("first_cor", cor, 8'h01);
    check("first_moving", moving, 1);
    check("first_facing", facing, 3);
    check("right_edge_cor2", cor2, 8'hff);
    check("right_edge_facing2", facing2, 3);
    repeat (4) tick;
    check("cool_cor", cor, 8'h01);
    check("cool_end_moving", moving, 0);
    tick;
    check("second_cor", cor, 8'h02);
    check("second_moving", moving, 1);
    btn_right = 1'b0;
    repeat (5) tick;
    move(2, 8'h01);
    move(1, 8'h11);
    wall_grid[8'h12] = 1'b1;
    btn_right = 1'b1;
    repeat (3) tick;
    check("wall_cor", cor, 8'h11);
    check("wall_facing", facing, 3);
    check("wall_moving", moving, 0);
    btn_right = 1'b0;
    wall_grid = '0;
    move(0, 8'h01);
    move(2, 8'h00);
    {btn_up, btn_left} = 2'b11;
    repeat (2) tick;
    check("upleft_cor", cor, 8'h00);
    check("upleft_facing", facing, 0);
    btn_left = 1'b0;
    btn_down = 1'b1;
    tick;
    check("updown_cor", cor, 8'h00);
    check("updown_facing", facing, 0);
    check("updown_moving", moving, 0);
    {btn_up, btn_down, btn_left} = 3'b001;
    tick;
    check("left_edge_cor", cor, 8'h00);
    check("left_edge_facing", facing, 2);
    btn_left = 1'b0;
    bomb_grid[8'h01] = 1'b1;
    btn_right = 1'b1;
    repeat (2) tick;
    check("bomb_tgt_cor", cor, 8'h00);
    check("bomb_tgt_facing", facing, 3);
    btn_right = 1'b0;
    bomb_grid = '0;
    btn_bomb = 1'b1;
    tick;
    check("set_pulse", set, 1);
    check("set_cor", cor, 8'h00);
    btn_bomb = 1'b0;
    tick;
    check("set_one_cycle", set, 0);
    btn_bomb = 1'b1;
    tick;
    check("hist_drop", set, 0);
    btn_bomb = 1'b0;
    tick;
    btn_bomb = 1'b1;
    tick;
    check("hist_clear_set", set, 1);
    btn_bomb = 1'b0;
    repeat (3) tick;
    bomb_cap = 3'd1;
    pulses = 0;
    btn_bomb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (set) pulses++;
      if (i == 0) check("cap_first", set, 1);
      if (i == 5) check("cap_second", set, 0);
      btn_bomb = (i == 3);
      if (i == 0) bomb_unexp_num = 3'd1;
    end
    check("cap_pulses", pulses, 1);
    bomb_cap = 3'd3;
    bomb_unexp_num = 3'd0;
    bomb_grid[8'h00] = 1'b1;
    btn_bomb = 1'b1;
    tick;
    check("own_cell_bomb", set, 0);
    btn_bomb = 1'b0;
    bomb_grid = '0;
    repeat (3) tick;
    move(1, 8'h10);
    move(1, 8'h20);
    move(3, 8'h21);
    move(3, 8'h22);
    btn_bomb = 1'b1;
    btn_down = 1'b1;
    tick;
    check("bvm_set", set, 1);
    check("bvm_cor", cor, 8'h22);
    check("bvm_moving", moving, 0);
    bomb_grid[8'h22] = 1'b1;
    btn_bomb = 1'b0;
    tick;
    check("bvm_next_cor", cor, 8'h32);
    check("bvm_next_set", set, 0);
    check("bvm_next_moving", moving, 1);
    btn_down = 1'b0;
    bomb_grid = '0;
    btn_up = 1'b1;
    game_over = 1'b1;
    tick;
    check("frz_facing_last", facing, 0);
    check("frz_moving", moving, 0);
    btn_up = 1'b0;
    btn_left = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      btn_bomb = i[0];
      tick;
      if (set) pulses++;
    end
    check("frz_sets", pulses, 0);
    check("frz_cor", cor, 8'h32);
    check("frz_facing", facing, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cor", cor, 8'h00);
    check("async_rst_facing", facing, 1);
    check("async_rst_set", set, 0);
    game_over = 1'b0;
    btn_bomb = 1'b0;
    btn_left = 1'b0;
    tick;
    rst_n = 1'b1;
    btn_right = 1'b1;
    tick;
    check("post_rst_cor", cor, 8'h01);
    check("post_rst_moving", moving, 1);
    btn_right = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
